// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register, writeback select, NZCV status register, forwarding tap and retired counter
module wb_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              flush,
   input  logic              mem_valid,
   input  logic              mem_wb_en,
   input  logic              mem_r_en,
   input  logic              mem_s,
   input  logic [REG_AW-1:0] mem_dest,
   input  logic [DATA_W-1:0] mem_alu,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic [3:0]        mem_nzcv,
   output logic              WBWriteEnable,
   output logic [REG_AW-1:0] WBDest,
   output logic [DATA_W-1:0] WBValue,
   output logic              N,
   output logic              Z,
   output logic              C,
   output logic              V,
   output logic              fwd_valid,
   output logic [REG_AW-1:0] fwd_dest,
   output logic [DATA_W-1:0] fwd_value,
   output logic [31:0]       retired
);
   logic              v, we, re;
   logic [REG_AW-1:0] dest;
   logic [DATA_W-1:0] alu, rdata;
   logic [3:0]        nzcv;
   logic              cap;
   assign cap = !flush && !freeze;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         v       <= 1'b0;
         we      <= 1'b0;
         re      <= 1'b0;
         dest    <= '0;
         alu     <= '0;
         rdata   <= '0;
         nzcv    <= 4'b0;
         retired <= 32'd0;
      end else begin
         if (flush) begin
            v  <= 1'b0;
            we <= 1'b0;
         end else if (!freeze) begin
            v     <= mem_valid;
            we    <= mem_wb_en & mem_valid;
            re    <= mem_r_en;
            dest  <= mem_dest;
            alu   <= mem_alu;
            rdata <= mem_rdata;
         end
         if (cap && mem_valid && mem_s) nzcv <= mem_nzcv;
         if (cap && mem_valid) retired <= retired + 32'd1;
      end
   assign WBWriteEnable = v & we;
   assign WBDest        = dest;
   assign WBValue       = re ? rdata : alu;
   assign {N, Z, C, V}  = nzcv;
   assign fwd_valid     = WBWriteEnable;
   assign fwd_dest      = WBDest;
   assign fwd_value     = WBValue;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed and random stimulus against a transaction-level model of the writeback stage
module tb_wb_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        freeze = 1'b0, flush = 1'b0;
   logic        mem_valid = 1'b0, mem_wb_en = 1'b0, mem_r_en = 1'b0, mem_s = 1'b0;
   logic [3:0]  mem_dest = '0;
   logic [31:0] mem_alu = '0, mem_rdata = '0;
   logic [3:0]  mem_nzcv = '0;
   logic        WBWriteEnable, N, Z, C, V, fwd_valid;
   logic [3:0]  WBDest, fwd_dest;
   logic [31:0] WBValue, fwd_value, retired;
   int          n_vec = 0, n_err = 0;
   logic        m_we = 1'b0;
   logic [3:0]  m_dest = '0;
   logic [31:0] m_val = '0;
   logic [3:0]  m_flags = '0;
   logic [31:0] m_ret = '0;

   wb_stage dut (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
      .mem_valid(mem_valid), .mem_wb_en(mem_wb_en), .mem_r_en(mem_r_en), .mem_s(mem_s),
      .mem_dest(mem_dest), .mem_alu(mem_alu), .mem_rdata(mem_rdata), .mem_nzcv(mem_nzcv),
      .WBWriteEnable(WBWriteEnable), .WBDest(WBDest), .WBValue(WBValue),
      .N(N), .Z(Z), .C(C), .V(V),
      .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_value(fwd_value), .retired(retired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_model();
      chk("we", WBWriteEnable, m_we);
      chk("fwd_valid", fwd_valid, m_we);
      if (m_we) begin
         chk("dest", WBDest, m_dest);
         chk("value", WBValue, m_val);
         chk("fwd_dest", fwd_dest, m_dest);
         chk("fwd_value", fwd_value, m_val);
      end
      chk("nzcv", {N, Z, C, V}, m_flags);
      chk("retired", retired, m_ret);
   endtask

   task automatic step();
      @(posedge clk);
      if (flush) m_we = 1'b0;
      else if (!freeze) begin
         m_we   = mem_valid & mem_wb_en;
         m_dest = mem_dest;
         m_val  = mem_r_en ? mem_rdata : mem_alu;
         if (mem_valid) begin
            if (mem_s) m_flags = mem_nzcv;
            m_ret = m_ret + 1;
         end
      end
      #1 check_model();
      @(negedge clk);
   endtask

   task automatic drive(input logic vl, input logic w, input logic r, input logic s,
                        input logic [3:0] d, input logic [31:0] a, input logic [31:0] rd,
                        input logic [3:0] f, input logic fl, input logic fr);
      mem_valid = vl; mem_wb_en = w; mem_r_en = r; mem_s = s;
      mem_dest = d; mem_alu = a; mem_rdata = rd; mem_nzcv = f;
      flush = fl; freeze = fr;
      step();
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_we", WBWriteEnable, 1'b0);
      chk("reset_value", WBValue, 32'd0);
      check_model();
      rst = 1'b0;
      drive(1, 1, 0, 0, 4'd3, 32'h0000_00A5, 32'h0, 4'h0, 0, 0);
      chk("alu_value", WBValue, 32'hA5);
      chk("alu_retired", retired, 32'd1);
      drive(1, 1, 1, 1, 4'd5, 32'h100, 32'hDEAD_BEEF, 4'b1010, 0, 0);
      chk("load_value", WBValue, 32'hDEAD_BEEF);
      chk("load_flags", {N, Z, C, V}, 4'b1010);
      drive(1, 1, 0, 0, 4'd6, 32'h7, 32'h0, 4'b0101, 0, 0);
      chk("s0_flags", {N, Z, C, V}, 4'b1010);
      for (int i = 0; i < 3; i++)
         drive(1, 1, i[0], 1, 4'(i + 8), 32'h1000 + i, 32'h2000 + i, 4'(i + 1), 0, 1);
      chk("freeze_value", WBValue, 32'h7);
      chk("freeze_we", WBWriteEnable, 1'b1);
      drive(1, 1, 0, 1, 4'd9, 32'h55, 32'h0, 4'b0011, 0, 0);
      chk("unfreeze_value", WBValue, 32'h55);
      drive(1, 1, 0, 1, 4'd2, 32'h66, 32'h0, 4'b1111, 1, 1);
      chk("flush_we", WBWriteEnable, 1'b0);
      chk("flush_flags", {N, Z, C, V}, 4'b0011);
      drive(0, 1, 0, 1, 4'd4, 32'h77, 32'h0, 4'b1100, 0, 0);
      chk("bubble_we", WBWriteEnable, 1'b0);
      drive(1, 1, 0, 0, 4'd15, 32'h8000_0000, 32'h0, 4'h0, 0, 0);
      chk("pc_dest", WBDest, 4'd15);
      freeze = 1'b1;
      #2 rst = 1'b1;
      #1;
      m_we = 1'b0; m_flags = 4'h0; m_ret = 32'd0;
      chk("midrst_we", WBWriteEnable, 1'b0);
      chk("midrst_value", WBValue, 32'd0);
      check_model();
      #1 rst = 1'b0;
      @(negedge clk);
      drive(0, 0, 0, 0, 4'd0, 32'h0, 32'h0, 4'h0, 0, 0);
      force dut.retired = 32'hFFFF_FFFF;
      #1 release dut.retired;
      m_ret = 32'hFFFF_FFFF;
      #1 chk("preload", retired, 32'hFFFF_FFFF);
      drive(1, 1, 0, 0, 4'd1, 32'h1, 32'h0, 4'h0, 0, 0);
      chk("wrap", retired, 32'd0);
      for (int i = 0; i < 400; i++)
         drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
               4'($urandom), $urandom, $urandom, 4'($urandom),
               $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback end of the register-file / status interface that the decode stage reads.
- Holds the MEM/WB pipeline register and selects the writeback value (ALU result or load data).
- Drives the register-file write port (WBWriteEnable, WBDest, WBValue) and owns the NZCV status register whose C, V, Z, N outputs feed decode's condition check.
- Also provides a forwarding tap and a retired-instruction counter.

Parameters:
- DATA_W, 32, datapath width
- REG_AW, 4, register index width (16 architectural registers)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- freeze  in  1  hold the stage register, status register and counter
- flush  in  1  insert a bubble into the stage
- mem_valid  in  1  upstream slot holds a real instruction
- mem_wb_en  in  1  instruction writes a register
- mem_r_en  in  1  instruction is a load (select memory data)
- mem_s  in  1  instruction updates flags
- mem_dest  in  REG_AW  destination register
- mem_alu  in  DATA_W  ALU result
- mem_rdata  in  DATA_W  load data
- mem_nzcv  in  4  flags from the ALU, bit3=N bit2=Z bit1=C bit0=V
- WBWriteEnable  out  1  register-file write strobe
- WBDest  out  REG_AW  register-file write index
- WBValue  out  DATA_W  register-file write data
- N, Z, C, V  out  1 each  status register bits
- fwd_valid  out  1  forwarding tap is valid (equals WBWriteEnable)
- fwd_dest  out  REG_AW  forwarding destination
- fwd_value  out  DATA_W  forwarding value
- retired  out  32  count of instructions that reached writeback

Behaviour:
- Reset (async, asserted rst): all stage registers, NZCV, retired and every output go to 0 immediately, independent of clk. Release is sampled on the next rising edge.
- Stage register fields: v, we, re, dest, alu, rdata.
- Capture condition: cap = !flush && !freeze.
- Edge priority:
  - flush=1: v<=0 and we<=0; other fields are don't-care. Flush wins over freeze.
  - freeze=1, flush=0: every field holds.
  - Otherwise: load v<=mem_valid, we<=mem_wb_en&mem_valid, re, dest, alu, rdata.
- Combinational outputs from the stage register (0 cycles after the edge):
  - WBWriteEnable = v & we
  - WBDest = dest
  - WBValue = re ? rdata : alu
  - fwd_* mirror WB*.
- Latency: inputs presented before edge k appear on WB* after edge k. WBWriteEnable is held for exactly one cycle per instruction unless frozen; while frozen it stays asserted, and the re-write is idempotent.
- Status register: at an edge with cap & mem_valid & mem_s, {N,Z,C,V} <= mem_nzcv. Otherwise it holds. Flags therefore become visible to the condition check in the same cycle the instruction's result is on WBValue.
- Retired counter: at an edge with cap & mem_valid, retired <= retired+1. Wraps modulo 2^32 with no saturation.
- Bubbles (mem_valid=0) never write a register, never update flags and never count, regardless of mem_wb_en / mem_s.
- dest=15 (PC) is written like any other register; no special handling.
- Simultaneous flush and freeze: treated as flush.
- rst asserted mid-freeze: clears the stage. After release the stage is empty and flags are 0.

Test Plan:
- Reset: assert rst mid-cycle with v=1 in the stage -> WBWriteEnable, WBValue, NZCV and retired read 0 before the next edge.
- ALU writeback: mem_valid=1, wb_en=1, r_en=0, dest=3, alu=0x0000_00A5 -> next cycle WBWriteEnable=1, WBDest=3, WBValue=0xA5, retired=1.
- Load select and flags: r_en=1, rdata=0xDEAD_BEEF, alu=0x100, s=1, nzcv=4'b1010 -> WBValue=0xDEADBEEF, N=1 Z=0 C=1 V=0 in the same cycle. A following s=0 instruction with nzcv=4'b0101 leaves NZCV at 1010.
- Freeze: hold freeze=1 for 3 cycles while the inputs change -> WB outputs, NZCV and retired unchanged. After release the new input is captured.
- Flush priority: flush=1 and freeze=1 together with mem_valid=1, s=1 -> WBWriteEnable=0, flags unchanged, retired unchanged.
- Counter wrap and bubble: preload retired to 0xFFFF_FFFF via 2^32-1 valid captures (or a force), then capture 1 valid -> retired=0. A bubble with wb_en=1 -> WBWriteEnable=0.
